adder_bist: RTL and testbench

Synthesizable built-in self-test engine for the ripple-carry adder family. It exhaustively drives every {a, b, c_in} combination into a combinational adder DUT, samples s and c_out after a settle delay, and compares them against an internal reference sum. It reports pass/fail, a saturating error count and the first failing vector. It is the hardware counterpart of the simulation-only stimulus benches: it sits beside the adder in the FPGA build and both drives the adder and checks its response.

---
 rtl/adder_bist.sv | 129 ++++++++++++
 tb/tb_adder_bist.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_bist.sv
// adder_bist: exhaustive built-in self-test engine for a combinational WIDTH-bit adder.
// Optional feature macro ADDER_BIST_STOP_ON_FAIL_EN ends a run at the first mismatching vector.
`timescale 1ns/1ps
module adder_bist #(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a,
    output logic [WIDTH-1:0]   b,
    output logic               c_in,
    input  logic [WIDTH-1:0]   s,
    input  logic               c_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [2*WIDTH:0]   fail_vec
);

    localparam int VW    = 2*WIDTH + 1;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [VW-1:0]    LAST_VEC   = '1;
    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_APPLY = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [VW-1:0]    r_vec;
    logic [CNT_W-1:0] r_settle_cnt;
    logic [ERR_W-1:0] r_err_count;
    logic [VW-1:0]    r_fail_vec;
    logic             r_failed;

    logic [WIDTH:0]   w_expected;
    logic             w_mismatch;
    logic             w_last;
    logic             w_err_full;
    logic             w_stop;

    // The vector register itself drives the DUT, so a/b/c_in are registered and
    // hold the last vector in DONE without extra storage.
    assign a    = r_vec[2*WIDTH:WIDTH+1];
    assign b    = r_vec[WIDTH:1];
    assign c_in = r_vec[0];

    assign w_expected = {1'b0, r_vec[2*WIDTH:WIDTH+1]}
                      + {1'b0, r_vec[WIDTH:1]}
                      + {{WIDTH{1'b0}}, r_vec[0]};
    assign w_mismatch = ({c_out, s} != w_expected);
    assign w_last     = (r_vec == LAST_VEC);
    assign w_err_full = &r_err_count;

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
    assign w_stop = w_last || w_mismatch;
`else
    assign w_stop = w_last;
`endif

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_vec        <= '0;
            r_settle_cnt <= '0;
            r_err_count  <= '0;
            r_fail_vec   <= '0;
            r_failed     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state      <= ST_APPLY;
                        r_vec        <= '0;
                        r_settle_cnt <= '0;
                        r_err_count  <= '0;
                        r_fail_vec   <= '0;
                        r_failed     <= 1'b0;
                    end
                end

                ST_APPLY: begin
                    if (r_settle_cnt == SETTLE_END) begin
                        r_state      <= ST_CHECK;
                        r_settle_cnt <= '0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + CNT_W'(1);
                    end
                end

                ST_CHECK: begin
                    if (w_mismatch) begin
                        if (!w_err_full) begin
                            r_err_count <= r_err_count + ERR_W'(1);
                        end
                        if (!r_failed) begin
                            r_fail_vec <= r_vec;
                            r_failed   <= 1'b1;
                        end
                    end
                    // The index never wraps: the last vector always ends the run.
                    if (w_stop) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_vec   <= r_vec + VW'(1);
                        r_state <= ST_APPLY;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (r_state == ST_APPLY) || (r_state == ST_CHECK);
    assign done      = (r_state == ST_DONE);
    assign pass      = done && (r_err_count == '0);
    assign err_count = r_err_count;
    assign fail_vec  = r_fail_vec;

endmodule

// File: tb/tb_adder_bist.sv
// tb_adder_bist: drives adder_bist against a fault-injectable adder model and checks
// every output each cycle against a timeline model derived from run arithmetic.
`timescale 1ns/1ps
module tb_adder_bist;

    localparam int W   = 2;
    localparam int S   = 2;
    localparam int EW  = 4;
    localparam int VW  = 2*W + 1;
    localparam int N   = 1 << VW;
    localparam int PER = S + 1;
    localparam int SAT = (1 << EW) - 1;

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          c_in;
    logic [W-1:0]  s;
    logic          c_out;
    logic          busy;
    logic          done;
    logic          pass;
    logic [EW-1:0] err_count;
    logic [VW-1:0] fail_vec;

    int n_total = 0;
    int n_bad   = 0;

    // XOR pattern applied to the adder's correct {c_out, s} for each vector index
    logic [W:0] corr [N];

    always #5 clk = ~clk;

    adder_bist #(.WIDTH(W), .SETTLE(S), .ERR_W(EW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .s         (s),
        .c_out     (c_out),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_vec  (fail_vec)
    );

    function automatic logic [W:0] vec_sum(input int v);
        int av, bv, cv;
        av = v >> (W + 1);
        bv = (v >> 1) % (1 << W);
        cv = v % 2;
        return (W+1)'(av + bv + cv);
    endfunction

    assign {c_out, s} = vec_sum(int'({a, b, c_in})) ^ corr[{a, b, c_in}];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    logic [W:0] m_corr [N];
    bit m_ran = 1'b0;
    int m_t   = 0;
    int m_end = 0;

    function automatic int run_length();
        if (STOP) begin
            for (int i = 0; i < N; i++)
                if (m_corr[i] != '0) return (i + 1) * PER;
        end
        return N * PER;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ran = 1'b0;
            m_t   = 0;
        end else if (start && !(m_ran && m_t < m_end)) begin
            m_ran  = 1'b1;
            m_t    = 0;
            m_corr = corr;
            m_end  = run_length();
        end else if (m_ran && m_t < m_end) begin
            m_t++;
        end
    end

    always @(negedge clk) begin
        int  vec, comp, errs, fv;
        bit  m_busy, found;
        vec = 0; comp = 0; errs = 0; fv = 0; found = 1'b0; m_busy = 1'b0;
        if (m_ran) begin
            m_busy = (m_t < m_end);
            vec    = m_busy ? (m_t / PER) : (m_end / PER - 1);
            comp   = (m_busy ? m_t : m_end) / PER;
            for (int i = 0; i < comp; i++) begin
                if (m_corr[i] != '0) begin
                    errs++;
                    if (!found) begin
                        fv    = i;
                        found = 1'b1;
                    end
                end
            end
            if (errs > SAT) errs = SAT;
        end
        check("m_busy", busy, m_busy);
        check("m_done", done, m_ran && !m_busy);
        check("m_pass", pass, m_ran && !m_busy && errs == 0);
        check("m_a", a, vec >> (W + 1));
        check("m_b", b, (vec >> 1) % (1 << W));
        check("m_c_in", c_in, vec % 2);
        check("m_err_count", err_count, errs);
        check("m_fail_vec", fail_vec, fv);
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // 0 clean, 1 c_out stuck at 0, 2 s[0] inverted, 3 last vector only, 4 random
    task automatic set_faults(input int mode);
        int dens;
        dens = $urandom_range(3, 12);
        for (int v = 0; v < N; v++) begin
            logic [W:0] good;
            good    = vec_sum(v);
            corr[v] = '0;
            case (mode)
                1: corr[v][W] = good[W];
                2: corr[v]    = (W+1)'(1);
                3: corr[v]    = (v == N - 1) ? (W+1)'(1) : '0;
                4: if ($urandom_range(0, dens) == 0)
                       corr[v] = (W+1)'($urandom_range(1, (1 << (W + 1)) - 1));
                default: corr[v] = '0;
            endcase
        end
    endtask

    // Returns edges from the start edge until done is seen; pokes start while busy if asked.
    task automatic run(input bit poke, output int e);
        start = 1'b1;
        step(1);
        start = 1'b0;
        e = 0;
        while (!done && e < N * PER + 16) begin
            start = poke && ($urandom_range(0, 15) == 0);
            step(1);
            start = 1'b0;
            e++;
        end
    endtask

    initial begin
        int e;
        rst   = 1'b1;
        start = 1'b0;
        set_faults(0);
        step(2);
        rst = 1'b0;
        step(1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_a", a, 0);

        // clean adder: full sweep, last vector 3+3+1 = 7 held
        run(1'b0, e);
        check("clean_latency", e, N * PER);
        check("clean_pass", pass, 1);
        check("clean_err", err_count, 0);
        check("clean_a", a, 3);
        check("clean_b", b, 3);
        check("clean_c_in", c_in, 1);
        check("clean_sum", {c_out, s}, 7);

        // c_out stuck at 0: 16 failing vectors, first is v=7 (a=0,b=3,c_in=1)
        set_faults(1);
        run(1'b0, e);
        check("cout_latency", e, STOP ? 8 * PER : N * PER);
        check("cout_err", err_count, STOP ? 1 : SAT);
        check("cout_fail_vec", fail_vec, 7);
        check("cout_pass", pass, 0);
        check("cout_a", a, STOP ? 0 : 3);

        // restart from DONE clears the error state on the next cycle
        set_faults(2);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("redo_busy", busy, 1);
        check("redo_done", done, 0);
        check("redo_err", err_count, 0);
        e = 0;
        while (!done && e < N * PER + 16) begin
            step(1);
            e++;
        end
        check("s0_latency", e, STOP ? PER : N * PER);
        check("s0_err", err_count, STOP ? 1 : SAT);
        check("s0_fail_vec", fail_vec, 0);

        // only the final vector is wrong
        set_faults(3);
        run(1'b1, e);
        check("last_latency", e, N * PER);
        check("last_err", err_count, 1);
        check("last_fail_vec", fail_vec, N - 1);

        // reset during APPLY of vector 5 (a=0,b=2,c_in=1), rst and start together
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(5 * PER);
        check("mid_a", a, 0);
        check("mid_b", b, 2);
        check("mid_c_in", c_in, 1);
        rst   = 1'b1;
        start = 1'b1;
        step(1);
        rst   = 1'b0;
        start = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_b", b, 0);
        check("abort_c_in", c_in, 0);
        step(2);
        set_faults(0);
        run(1'b1, e);
        check("rerun_latency", e, N * PER);
        check("rerun_pass", pass, 1);

        // randomized fault maps, with start poked while busy
        for (int r = 0; r < 8; r++) begin
            set_faults(4);
            step($urandom_range(0, 3));
            run(1'b1, e);
            check("rand_latency", e, m_end);
        end

        step(2);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
